// File: rtl/demux_1_para_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready flow control and a one-entry holding register per channel.
// Optional macro DEMUX_ROUND_ROBIN_EN replaces the {S1,S0} select with an internal round-robin pointer.
module demux_1_para_4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3
);

  logic [1:0]       sel;
  logic [3:0]       r_vec;
  logic [3:0]       load;
  logic             accept;
  logic [3:0]       v_q, v_d;
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];

  assign r_vec = {R3, R2, R1, R0};

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_sel;

  assign unused_sel = S0 ^ S1;
  assign sel        = ptr_q;

  // The pointer only advances on accepted words, so a stall parks it on the blocked channel.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign sel = {S1, S0};
`endif

  assign in_ready = ~v_q[sel] | r_vec[sel];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_load
      assign load[gi] = accept & (sel == 2'(gi));
    end
  endgenerate

  // A load on the same edge as a drain wins, so the channel stays valid with the new word.
  always_comb begin
    v_d = v_q & ~r_vec;
    for (int i = 0; i < 4; i++) begin
      y_d[i] = y_q[i];
      if (load[i]) begin
        v_d[i] = 1'b1;
        y_d[i] = D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign V0 = v_q[0];
  assign V1 = v_q[1];
  assign V2 = v_q[2];
  assign V3 = v_q[3];

endmodule

// File: doc/demux_1_para_4_reg.md
# demux_1_para_4_reg

Registered 1-to-4 demultiplexer with valid/ready flow control, the distributing counterpart of the ALU's 4-to-1 operand/result selection path. It accepts one WIDTH-bit word per handshake on a single input channel and delivers it to one of four output channels. Each output has its own one-entry holding register, so a stalled consumer blocks only its own channel. Selection comes from the 2-bit select input or, when compiled in, an internal round-robin pointer.

## Interface
- WIDTH, 4: data word width in bits (≥1).
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-high; one clock cycle with rst=1 resets.
- D  input  WIDTH  input data word.
- S0, S1  input  1 each  channel select; channel index = {S1,S0}. Ignored when round-robin is compiled in.
- in_valid  input  1  D (and S) carry a word.
- in_ready  output  1  block accepts the word this cycle.
- Y0, Y1, Y2, Y3  output  WIDTH each  channel data registers.
- V0, V1, V2, V3  output  1 each  channel holds an undelivered word.
- R0, R1, R2, R3  input  1 each  channel consumer accepts the word this cycle.

## Operation
- Target channel sel = {S1,S0} (or the internal pointer, see Configuration).
- Channel i is full when Vi=1. in_ready = ~V[sel] | R[sel]; purely combinational, no dependence on in_valid.
- Accept: in_valid & in_ready at a rising edge → Y[sel] <= D, V[sel] <= 1.
- Drain: Vi & Ri at a rising edge → Vi <= 0, unless channel i is loaded on the same edge.
- Simultaneous drain and load on the same channel: new word replaces old, Vi stays 1, no bubble.
- Drains on other channels proceed independently in the same cycle as an accept.
- Yi keeps its last value after draining; consumers qualify Yi with Vi only.
- Ri is ignored while Vi=0.
- Source rule: while in_valid=1 and in_ready=0, D and select hold stable. The block does not check this; behaviour is defined by the values present on the accepting edge.
- No words are dropped or duplicated; every accepted word appears exactly once on exactly one channel.

## Timing
- Reset (rst=1 at an edge): V0..V3=0, Y0..Y3=0, round-robin pointer=0. in_ready evaluates to 1 after reset.
- Latency: a word accepted at edge n is visible on Y[sel] with V[sel]=1 after edge n, in cycle n+1.
- Throughput: one word per cycle sustained to any single channel whose consumer holds Ri=1.
- A stalled channel (Vi=1, Ri=0) blocks input only while it is selected.
- rst has priority over accept and drain on the same edge. Words in flight are discarded, with no partial state.
- Changing select with in_valid=0 has no effect on state.

## Configuration
- Macro DEMUX_ROUND_ROBIN_EN.
- Defined:
  - S0/S1 are ignored.
  - sel is a 2-bit internal pointer, reset to 0.
  - The pointer increments mod 4 (3→0) on every accepted word, and only on accepted words.
  - in_ready uses the pointer's channel.
- Not defined: sel = {S1,S0}, there is no pointer register, and behaviour is exactly as in Operation.

## Test plan
- Reset, then accept D=4'hA with S=2 and R=0 → after one edge Y2=A, V2=1, V0/V1/V3=0, in_ready stays 1 for S=0,1,3 and is 0 for S=2.
- Fill channel 1 with 4'h3 and hold R1=0, offer 4'h5 on S=1 → in_ready=0, Y1 stays 3. Raise R1 → 5 is accepted on that edge, Y1=5, V1 stays 1.
- Stream 4'h1..4'h8 to S=3 with R3=1 continuously → eight consecutive accepts, Y3 follows one cycle later, V3 is never low between words.
- Load all four channels (values 1,2,3,4), then drain in order 3,0,2,1 → each Vi falls only on its own Ri edge, data matches, and no other channel changes.
- Assert rst while V0=V2=1 and in_valid=1 → next cycle all Vi=0 and all Yi=0, and the offered word is not captured.
- With DEMUX_ROUND_ROBIN_EN defined, all R=1 and S held at 0, send 6 words → they land on channels 0,1,2,3,0,1. A stall on channel 2 blocks the pointer at 2 until R2 is asserted.
